hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of destination-register info for the EX, MEM and WB stages.
- Generates stall, bubble and flush enables for the PC, IF/ID and ID/EX registers.
- Generates registered forwarding selects for the two EX operand muxes (busA/busB).

Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, width of the saturating stall/flush performance counters

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs  in  REG_W  rs field of instruction in ID
- id_rt  in  REG_W  rt field of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt (R-type, sw, beq, bne)
- id_dst  in  REG_W  write target chosen in ID (rd, rt, or 31 for jal)
- id_regwr  in  1  ID instruction writes a register
- id_mem2reg  in  1  ID instruction is a load
- ex_redirect  in  1  branch/jump/jr taken, resolved in EX this cycle
- mem_busy  in  1  data memory not ready; freeze whole pipe
- pc_en  out  1  PC may advance
- ifid_en  out  1  IF/ID register may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a NOP (all control signals 0)
- fwd_a  out  2  EX busA select: 00 regfile, 01 MEM-stage ALU result, 10 WB data
- fwd_b  out  2  EX busB select, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- Scoreboard: three slots EX, MEM and WB. Each slot holds {valid, dst, regwr, mem2reg}.
  - Normal advance: ID info goes to EX, EX to MEM, MEM to WB, and WB is dropped.
  - An entry hazards only if valid && regwr && dst != 0.
- Register file is write-through: a WB write is visible to the same-cycle ID read. WB-slot matches at ID time need no forwarding.
- Load-use hazard (lu): id_valid && EX slot is a load && EX.dst matches (id_use_rs && id_rs) or (id_use_rt && id_rt).
- Priority per cycle: rst > mem_busy > ex_redirect > lu > normal.
  - rst: all slots invalid, fwd_a = fwd_b = 00, counters = 0. Combinational outputs during rst: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
  - mem_busy: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0. Slots, fwd and counters hold (ID/EX also frozen by datapath via same stall).
  - ex_redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. EX slot becomes invalid (bubble); EX→MEM and MEM→WB still advance (redirecting instruction completes). fwd_a/fwd_b become 00. flush_cnt++ (saturate).
  - lu: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1. EX slot becomes invalid and others advance. fwd becomes 00. stall_cnt++ (saturate).
  - normal: pc_en=1, ifid_en=1, flush=0, bubble=0. ID info loads into EX slot (valid = id_valid).
- Forwarding select is registered: computed from ID sources vs pre-edge slots, loaded on the same edge the ID instruction enters EX.
  - If EX.dst matches src and EX is not a load: 01 (producer will be in MEM).
  - Else if MEM.dst matches src: 10 (producer will be in WB).
  - Else: 00. EX takes precedence over MEM (youngest wins).
  - Source register 0 or unused source always gives 00.
- Latency: lu stalls exactly 1 cycle. After the stall the load is in MEM, and the retried ID gets fwd 10.
- Redirect plus lu in the same cycle: redirect wins, no stall counted.
- Reset mid-stall: the stall is abandoned and the slots are cleared.
- Counters stop at all-ones.

Test Plan:
- Reset: hold rst 2 cycles → pc_en=0, ifid_flush=1, idex_bubble=1, fwd 00/00, counters 0. First cycle after release → pc_en=1, bubble=0.
- EX forward: add $3 in ID, next cycle sub $5,$3,$4 in ID → on the following edge fwd_a=01, fwd_b=00, no stall.
- Load-use: lw $2 then add $4,$2,$2 → one cycle with pc_en=0, ifid_en=0, idex_bubble=1. Then add enters EX with fwd_a=fwd_b=10; stall_cnt=1.
- $0 destination: addi $0 followed by use of $0 → fwd 00, no stall.
- Redirect: ex_redirect pulse with lw-use pending in ID → ifid_flush=1, idex_bubble=1, stall_cnt unchanged, flush_cnt=1.
- mem_busy held 3 cycles during a forward pair → all enables 0, slots unchanged. After release the forward still resolves to the pre-freeze value (fwd_a=01).

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU: PC / IF/ID / ID/EX enables plus EX forwarding selects.
// Latency: enables are combinational from the current ID fields; fwd_a/fwd_b register on the edge the ID instruction enters EX.
// Backpressure: mem_busy freezes everything, a taken redirect flushes IF/ID and ID/EX, and a load-use hazard stalls exactly one cycle.
//
// Ports:
//   clk, rst                       pipeline clock, synchronous active-high reset
//   id_valid/id_rs/id_rt           ID instruction presence and source register fields
//   id_use_rs/id_use_rt            which of those sources the ID instruction actually reads
//   id_dst/id_regwr/id_mem2reg     ID write target, register-write flag and load flag
//   ex_redirect, mem_busy          taken branch/jump resolved in EX; data memory not ready
//   pc_en, ifid_en, ifid_flush,
//   idex_bubble                    pipeline register controls
//   fwd_a, fwd_b                   EX operand selects (00 regfile, 01 MEM ALU result, 10 WB data)
//   stall_cnt, flush_cnt           saturating load-use stall and redirect counters
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwr,
  input  logic             id_mem2reg,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwr;
    logic             mem2reg;
  } slot_t;

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu;

  // A slot produces a value for src only if it really writes a nonzero register.
  function automatic logic hits(input slot_t s, input logic [REG_W-1:0] src, input logic use_src);
    return use_src && (src != '0) && s.valid && s.regwr && (s.dst == src);
  endfunction

  // Youngest producer wins. A load in EX cannot forward (its data is not ready
  // yet); that case is caught by the load-use stall instead.
  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                         input logic [REG_W-1:0] src, input logic use_src);
    if (hits(ex, src, use_src) && !ex.mem2reg) return 2'b01;
    else if (hits(mem, src, use_src))          return 2'b10;
    else                                       return 2'b00;
  endfunction

  assign lu = id_valid && ex_q.mem2reg &&
              (hits(ex_q, id_rs, id_use_rs) || hits(ex_q, id_rt, id_use_rt));

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (rst) begin
      ex_d        = '0;
      mem_d       = '0;
      wb_d        = '0;
      fwd_a_d     = 2'b00;
      fwd_b_d     = 2'b00;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (ex_redirect) begin
      // The redirecting instruction itself still retires, so older slots advance.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      ex_d        = '0;
      mem_d       = ex_q;
      wb_d        = mem_q;
      fwd_a_d     = 2'b00;
      fwd_b_d     = 2'b00;
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      ex_d        = '0;
      mem_d       = ex_q;
      wb_d        = mem_q;
      fwd_a_d     = 2'b00;
      fwd_b_d     = 2'b00;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid   = id_valid;
      ex_d.dst     = id_dst;
      ex_d.regwr   = id_regwr;
      ex_d.mem2reg = id_mem2reg;
      mem_d        = ex_q;
      wb_d         = mem_q;
      fwd_a_d      = fwd_sel(ex_q, mem_q, id_rs, id_use_rs);
      fwd_b_d      = fwd_sel(ex_q, mem_q, id_rt, id_use_rt);
    end
  end

  always_ff @(posedge clk) begin
    ex_q        <= ex_d;
    mem_q       <= mem_d;
    wb_q        <= wb_d;
    fwd_a_q     <= fwd_a_d;
    fwd_b_q     <= fwd_b_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: reset, EX/MEM forwarding, load-use stall,
// $0 handling, redirect priority, mem_busy freeze, counter saturation, reset mid-stall.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_dst;
  logic             id_use_rs, id_use_rt, id_regwr, id_mem2reg;
  logic             ex_redirect, mem_busy;
  logic             pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dst(id_dst), .id_regwr(id_regwr), .id_mem2reg(id_mem2reg),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; return 1 time unit later so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input int dst, input logic rw, input logic m2r);
    id_valid   = v;
    id_rs      = REG_W'(rs);
    id_rt      = REG_W'(rt);
    id_use_rs  = urs;
    id_use_rt  = urt;
    id_dst     = REG_W'(dst);
    id_regwr   = rw;
    id_mem2reg = m2r;
  endtask

  task automatic chk_en(input string tag, input logic pc, input logic ie,
                        input logic fl, input logic bb);
    #1;
    chk({tag, ".pc_en"},       32'(pc_en),       32'(pc));
    chk({tag, ".ifid_en"},     32'(ifid_en),     32'(ie));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bb));
  endtask

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; mem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held for two edges.
    tick(); tick();
    chk_en("rst", 0, 0, 1, 1);
    chk("rst.fwd_a", 32'(fwd_a), 0);
    chk("rst.fwd_b", 32'(fwd_b), 0);
    chk("rst.stall_cnt", 32'(stall_cnt), 0);
    chk("rst.flush_cnt", 32'(flush_cnt), 0);
    rst = 1'b0;
    chk_en("post_rst", 1, 1, 0, 0);

    // add $3,$1,$2 then sub $5,$3,$4: EX forward on busA.
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    set_id(1, 3, 4, 1, 1, 5, 1, 0);
    chk_en("exfwd", 1, 1, 0, 0);
    tick();
    chk("exfwd.fwd_a", 32'(fwd_a), 32'h1);
    chk("exfwd.fwd_b", 32'(fwd_b), 32'h0);

    // lw $2,0($1) then add $4,$2,$2: one stall, then WB forwarding on both.
    set_id(1, 1, 2, 1, 0, 2, 1, 1);
    tick();
    chk("lw.fwd_a", 32'(fwd_a), 32'h0);
    set_id(1, 2, 2, 1, 1, 4, 1, 0);
    chk_en("lu.stall", 0, 0, 0, 1);
    tick();
    chk("lu.stall_cnt", 32'(stall_cnt), 1);
    chk("lu.fwd_a_bubble", 32'(fwd_a), 32'h0);
    chk_en("lu.retry", 1, 1, 0, 0);
    tick();
    chk("lu.fwd_a", 32'(fwd_a), 32'h2);
    chk("lu.fwd_b", 32'(fwd_b), 32'h2);
    chk("lu.stall_cnt_hold", 32'(stall_cnt), 1);

    // addi $0,$1,5 then add $6,$0,$0: $0 never forwards.
    set_id(1, 1, 0, 1, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 0, 1, 1, 6, 1, 0);
    chk_en("zero", 1, 1, 0, 0);
    tick();
    chk("zero.fwd_a", 32'(fwd_a), 32'h0);
    chk("zero.fwd_b", 32'(fwd_b), 32'h0);

    // lw $7 then dependent add while a redirect resolves: redirect wins.
    set_id(1, 1, 7, 1, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 0, 1, 1, 8, 1, 0);
    ex_redirect = 1'b1;
    chk_en("redir", 1, 1, 1, 1);
    tick();
    ex_redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("redir.stall_cnt", 32'(stall_cnt), 1);
    chk("redir.flush_cnt", 32'(flush_cnt), 1);
    chk("redir.fwd_a", 32'(fwd_a), 32'h0);

    // add $9 then sub $10,$9,$1 with mem_busy held for three edges.
    set_id(1, 1, 2, 1, 1, 9, 1, 0);
    tick();
    set_id(1, 9, 1, 1, 1, 10, 1, 0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_en("busy", 0, 0, 0, 0);
      tick();
      chk("busy.fwd_a", 32'(fwd_a), 32'h0);
      chk("busy.flush_cnt", 32'(flush_cnt), 1);
    end
    mem_busy = 1'b0;
    chk_en("busy.release", 1, 1, 0, 0);
    tick();
    chk("busy.fwd_a_after", 32'(fwd_a), 32'h1);
    chk("busy.fwd_b_after", 32'(fwd_b), 32'h0);

    // Redirect held for 16 edges: 4-bit flush counter saturates at 15.
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    ex_redirect = 1'b0;
    chk("sat.flush_cnt", 32'(flush_cnt), 32'hF);
    chk("sat.stall_cnt", 32'(stall_cnt), 1);

    // Reset arrives while a load-use stall is pending.
    set_id(1, 1, 2, 1, 0, 2, 1, 1);
    tick();
    set_id(1, 2, 3, 1, 1, 4, 1, 0);
    chk_en("rststall.pre", 0, 0, 0, 1);
    rst = 1'b1;
    chk_en("rststall.rst", 0, 0, 1, 1);
    tick();
    chk("rststall.stall_cnt", 32'(stall_cnt), 0);
    chk("rststall.flush_cnt", 32'(flush_cnt), 0);
    rst = 1'b0;
    chk_en("rststall.after", 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
